// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM state encoding and
// the 2-byte opcode classifier.
package fetch_pkg;

   typedef enum logic [2:0] {
      BOOT_ADDR,
      BOOT_DATA,
      REQ,
      OP,
      IMM,
      HOLD
   } fetch_state_e;

   localparam logic [3:0] TWO_BYTE_OPC_DEF = 4'hC;

   // Upper nibble of the opcode selects the 2-byte (opcode + immediate) format.
   function automatic logic is_two_byte(input logic [7:0] opcode,
                                        input logic [3:0] key);
      return opcode[7:4] == key;
   endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: drives memory port A, assembles 1/2-byte instructions,
// owns the PC. Define FETCH_BOOT_VECTOR_EN to load the start PC from M[0].
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                 ADDR_W       = 8,
   parameter int                 DATA_W       = 8,
   parameter logic [ADDR_W-1:0]  RESET_PC     = 8'h00,
   parameter logic [3:0]         TWO_BYTE_OPC = TWO_BYTE_OPC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_opcode,
   output logic [DATA_W-1:0] out_imm,
   output logic              out_len2,
   output logic [ADDR_W-1:0] out_pc
);

`ifdef FETCH_BOOT_VECTOR_EN
   localparam fetch_state_e      RST_STATE = BOOT_ADDR;
   localparam logic [ADDR_W-1:0] RST_PC    = '0;
`else
   localparam fetch_state_e      RST_STATE = REQ;
   localparam logic [ADDR_W-1:0] RST_PC    = RESET_PC;
`endif

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] out_pc_q, out_pc_d;
   logic [DATA_W-1:0] opcode_q, opcode_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic              len2_q, len2_d;
   logic              valid_q, valid_d;
   logic              rdata_two;

   assign rdata_two = is_two_byte(mem_rdata[DATA_W-1 -: 8], TWO_BYTE_OPC);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RST_STATE;
         pc_q     <= RST_PC;
         out_pc_q <= '0;
         opcode_q <= '0;
         imm_q    <= '0;
         len2_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         out_pc_q <= out_pc_d;
         opcode_q <= opcode_d;
         imm_q    <= imm_d;
         len2_q   <= len2_d;
         valid_q  <= valid_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      out_pc_d = out_pc_q;
      opcode_d = opcode_q;
      imm_d    = imm_q;
      len2_d   = len2_q;
      mem_addr = pc_q;
      case (state_q)
`ifdef FETCH_BOOT_VECTOR_EN
         BOOT_ADDR: begin
            mem_addr = '0;
            state_d  = BOOT_DATA;
         end
         BOOT_DATA: begin
            mem_addr = '0;
            pc_d     = mem_rdata[ADDR_W-1:0];
            state_d  = REQ;
         end
`endif
         REQ: state_d = OP;
         OP: begin
            // Immediate address is presented unconditionally; the read is only
            // consumed when the opcode turns out to be 2-byte.
            mem_addr = pc_q + 1'b1;
            opcode_d = mem_rdata;
            out_pc_d = pc_q;
            len2_d   = rdata_two;
            if (rdata_two) begin
               state_d = IMM;
            end else begin
               imm_d   = '0;
               state_d = HOLD;
            end
         end
         IMM: begin
            imm_d   = mem_rdata;
            state_d = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               pc_d    = pc_q + ADDR_W'(len2_q ? 2 : 1);
               state_d = REQ;
            end
         end
         default: state_d = RST_STATE;
      endcase
      // A HOLD handshake in the same cycle still completes; only the PC source changes.
      if (redirect_valid && (state_q inside {REQ, OP, IMM, HOLD})) begin
         pc_d    = redirect_pc;
         state_d = REQ;
      end
   end

   assign valid_d    = (state_d == HOLD);
   assign out_valid  = valid_q;
   assign out_opcode = opcode_q;
   assign out_imm    = imm_q;
   assign out_len2   = len2_q;
   assign out_pc     = out_pc_q;

endmodule
